// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster timing outputs shared by the generator and pixel sources
interface vga_timing_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_end;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_end, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, line_end, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster counters, visible-area decode and delayed syncs
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_if.master     vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] fc_q, fc_d;
    logic       hs_raw, vs_raw;

    always_comb begin
        x_d  = x_q + 10'd1;
        y_d  = y_q;
        fc_d = fc_q;
        if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d  = 10'd0;
                fc_d = fc_q + 8'd1;
            end else begin
                y_d = y_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_q  <= 10'd0;
            y_q  <= 10'd0;
            fc_q <= 8'd0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    // Visible-area and strobe decodes track the counters directly; only the syncs are delayed.
    assign hs_raw = !((x_q >= HS_START) && (x_q < HS_END));
    assign vs_raw = !((y_q >= VS_START) && (y_q < VS_END));

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.frame_count = fc_q;
    assign vga.blank       = (x_q < H_VIS) && (y_q < V_VIS);
    assign vga.line_end    = (x_q == H_LAST);
    assign vga.frame_start = (x_q == 10'd0) && (y_q == 10'd0);

    generate
        if (SYNC_DELAY == 0) begin : g_sync_direct
            assign vga.hs = hs_raw;
            assign vga.vs = vs_raw;
        end else begin : g_sync_pipe
            // Matches the one-posedge colour register in the pixel sources so syncs align at the pins.
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                hs_pipe_d[0] = hs_raw;
                vs_pipe_d[0] = vs_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    hs_pipe_d[i] = hs_pipe_q[i-1];
                    vs_pipe_d[i] = vs_pipe_q[i-1];
                end
            end

            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign vga.hs = hs_pipe_q[SYNC_DELAY-1];
            assign vga.vs = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen across three parameter sets
module tb_vga_timing_gen;
    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 vga_clk = ~vga_clk;

    vga_timing_if if0();
    vga_timing_if if1();
    vga_timing_if if2();

    // Full horizontal timing, short frame so several frames fit in the run.
    vga_timing_gen #(
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(1)
    ) u_dut0 (.vga_clk(vga_clk), .reset(reset), .vga(if0));

    // Tiny raster so frame_count wraps within the run; raw syncs.
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(0)
    ) u_dut1 (.vga_clk(vga_clk), .reset(reset), .vga(if1));

    // Tiny raster with the deepest legal sync pipeline.
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(3)
    ) u_dut2 (.vga_clk(vga_clk), .reset(reset), .vga(if2));

    typedef struct {
        int          id;
        longint      n;
        logic [63:0] v;
    } exp_t;

    exp_t   sb[$];
    int     tests_run = 0;
    int     tests_failed = 0;
    longint n = 0;
    int     hs0_low_line0 = 0;
    int     vs0_low_frame0 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [9:0] x, input logic [9:0] y,
                                         input logic b, input logic h, input logic v,
                                         input logic le, input logic fs, input logic [7:0] fc);
        return {31'd0, x, y, b, h, v, le, fs, fc};
    endfunction

    // Expected outputs n cycles after reset, derived from absolute cycle position.
    function automatic logic [63:0] model(input longint cyc, input int hv, input int hf,
                                          input int hsy, input int hb, input int vv,
                                          input int vf, input int vsy, input int vb,
                                          input int d);
        longint ht, vt, x, y, fc, m, mx, my;
        logic h, v;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        x  = cyc % ht;
        y  = (cyc / ht) % vt;
        fc = (cyc / (ht * vt)) % 256;
        h  = 1'b1;
        v  = 1'b1;
        m  = cyc - d;
        if (m >= 0) begin
            mx = m % ht;
            my = (m / ht) % vt;
            h  = !((mx >= hv + hf) && (mx < hv + hf + hsy));
            v  = !((my >= vv + vf) && (my < vv + vf + vsy));
        end
        return pack(10'(x), 10'(y), (x < hv) && (y < vv), h, v,
                    x == ht - 1, (x == 0) && (y == 0), 8'(fc));
    endfunction

    function automatic logic [63:0] observe(input int id);
        case (id)
            0: return pack(if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs,
                           if0.line_end, if0.frame_start, if0.frame_count);
            1: return pack(if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs,
                           if1.line_end, if1.frame_start, if1.frame_count);
            default: return pack(if2.DrawX, if2.DrawY, if2.blank, if2.hs, if2.vs,
                                 if2.line_end, if2.frame_start, if2.frame_count);
        endcase
    endfunction

    task automatic cycle(input logic r);
        exp_t e;
        reset = r;
        if (r) n = 0;
        else   n = n + 1;
        sb.push_back('{id: 0, n: n, v: model(n, 640, 16, 96, 48, 8, 2, 2, 3, 1)});
        sb.push_back('{id: 1, n: n, v: model(n, 4, 1, 2, 1, 3, 1, 1, 1, 0)});
        sb.push_back('{id: 2, n: n, v: model(n, 4, 1, 2, 1, 3, 1, 1, 1, 3)});
        @(posedge vga_clk);
        @(negedge vga_clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("dut%0d n=%0d", e.id, e.n), observe(e.id), e.v);
        end
    endtask

    initial begin
        cycle(1'b1);
        cycle(1'b1);
        check_eq("rst_frame_start", 64'(if0.frame_start), 64'd1);
        check_eq("rst_blank", 64'(if0.blank), 64'd1);
        check_eq("rst_hs_vs", 64'({if0.hs, if0.vs}), 64'd3);

        // Two full frames of dut0, well past the 256-frame wrap of the tiny rasters.
        for (int i = 0; i < 25000; i++) begin
            cycle(1'b0);
            if (n < 800 && !if0.hs) hs0_low_line0++;
            if (n < 12000 && !if0.vs) vs0_low_frame0++;
        end
        check_eq("hs0_width", 64'(hs0_low_line0), 64'd96);
        check_eq("vs0_width", 64'(vs0_low_frame0), 64'd1600);
        check_eq("fc0_after_2_frames", 64'(if0.frame_count), 64'd2);

        // Reset while both syncs are active at (700, 11).
        cycle(1'b1);
        while (n < 11 * 800 + 700) cycle(1'b0);
        check_eq("mid_x", 64'(if0.DrawX), 64'd700);
        check_eq("mid_hs_low", 64'(if0.hs), 64'd0);
        check_eq("mid_vs_low", 64'(if0.vs), 64'd0);
        cycle(1'b1);
        check_eq("mid_rst_xy", 64'({if0.DrawX, if0.DrawY}), 64'd0);
        check_eq("mid_rst_sync", 64'({if0.hs, if0.vs}), 64'd3);
        check_eq("mid_rst_fc", 64'(if0.frame_count), 64'd0);
        for (int i = 0; i < 1000; i++) cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing: pixel coordinates DrawX/DrawY, the display-enable `blank`, and active-low hs/vs sync to the monitor.
- Drives every pixel-source module, e.g. the menu and maze renderers. Those modules look up a ROM on the negedge and register their colour on the next posedge.
- Because of that, hs/vs are delayed by SYNC_DELAY cycles so the syncs line up with the registered colour at the VGA pins.
- Also produces frame/line strobes and a frame counter for animation and game logic.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_DELAY, 1, pipeline depth applied to hs/vs only; legal range 0..3

Ports:
- vga_clk  input  1  pixel clock (25 MHz nominal)
- reset  input  1  synchronous, active-high reset
- DrawX  output  10  current horizontal counter, 0..H_TOTAL-1
- DrawY  output  10  current vertical counter, 0..V_TOTAL-1
- blank  output  1  1 = DrawX/DrawY inside the visible area (pixel sources drive colour only when high)
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY cycles
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY cycles
- line_end  output  1  one-cycle pulse when DrawX == H_TOTAL-1
- frame_start  output  1  one-cycle pulse when DrawX == 0 and DrawY == 0
- frame_count  output  8  frames completed since reset, wraps 255 -> 0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Counters, evaluated on each posedge vga_clk:
  - DrawX increments by 1.
  - At H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At DrawX == H_TOTAL-1 with DrawY == V_TOTAL-1, both wrap to 0 and frame_count increments.
- blank, line_end and frame_start are decoded from the registered counters with no delay; they always describe the current DrawX/DrawY.
  - blank = (DrawX < H_VISIBLE) and (DrawY < V_VISIBLE).
- Raw horizontal sync is low while H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- Raw vertical sync is low while V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491, for the whole of each line.
- hs/vs are the raw syncs passed through a SYNC_DELAY-stage register shift chain.
  - With SYNC_DELAY = 0 they are the raw decode.
  - Pipeline stages reset to 1 (inactive).
- Reset (synchronous, takes priority over counting):
  - DrawX = 0, DrawY = 0, frame_count = 0.
  - hs = 1, vs = 1, all delay stages = 1.
  - Consequently blank = 1, frame_start = 1, line_end = 0 on the cycle after reset is sampled.
  - Reset asserted mid-frame or mid-sync aborts immediately; no partial-sync completion.
  - The first post-reset sync pulse appears SYNC_DELAY cycles after DrawX reaches 656.
- No state machine beyond the counters. The porch/sync/visible regions are pure compares; there are no other states.
- Widths: all compares are done on 10-bit unsigned values; no overflow for the defaults. The counter width must cover H_TOTAL-1 and V_TOTAL-1 (max 1023).
- Simultaneous events: the line wrap and frame wrap happen in the same cycle at (799,524). line_end is high in that cycle; frame_start is high in the following cycle.

Test Plan:
- Reset, then release → cycle 0: DrawX=0, DrawY=0, blank=1, frame_start=1, hs=vs=1, frame_count=0. After 639 cycles DrawX=639, blank=1; next cycle DrawX=640, blank=0.
- Line wrap → at DrawX=799, line_end=1. Next cycle DrawX=0, DrawY=1, line_end=0, blank=1.
- hs timing, SYNC_DELAY=1 → hs falls one cycle after DrawX=656 is presented, stays low exactly 96 cycles, and rises one cycle after DrawX=752.
- Frame timing → vs low exactly 2×800=1600 cycles, starting one cycle after (DrawX=0, DrawY=490). blank=0 for every DrawY 480..524. Frame length = 420000 cycles. frame_count reads 1 after the first wrap and 255→0 after 256 frames.
- Reset mid-sync → assert reset at DrawX=700, DrawY=491 (hs, vs both low) → next cycle DrawX=0, DrawY=0, hs=vs=1, frame_count=0.
- SYNC_DELAY=0 build → hs low exactly while DrawX is 656..751, same cycle as the counter; vs low exactly while DrawY is 490..491.
